// File: rtl/alu16_arbiter_pkg.sv
// Shared definitions for the two-requester Hack ALU arbiter.
package alu16_arbiter_pkg;

  // Hack ALU control words {zx,nx,zy,ny,f,no}
  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_ONE  = 6'b111111;
  localparam logic [5:0] ALU_NEG1 = 6'b111010;
  localparam logic [5:0] ALU_X    = 6'b001100;
  localparam logic [5:0] ALU_Y    = 6'b110000;
  localparam logic [5:0] ALU_NOTX = 6'b001101;
  localparam logic [5:0] ALU_NEGX = 6'b001111;
  localparam logic [5:0] ALU_ADD  = 6'b000010;
  localparam logic [5:0] ALU_SUB  = 6'b010011;
  localparam logic [5:0] ALU_AND  = 6'b000000;
  localparam logic [5:0] ALU_OR   = 6'b010101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_op_t;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic grant_t pick_winner(input logic req_a, input logic req_b,
                                         input grant_t last_grant);
    grant_t w;
    if (req_a && req_b) begin
      w = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (req_b) begin
      w = GRANT_B;
    end else begin
      w = GRANT_A;
    end
    return w;
  endfunction

endpackage

// File: rtl/alu16_arbiter_alu.sv
// Combinational Hack ALU: conditional zero/negate of each operand, add or AND,
// optional output negate, plus zero and negative flags.
module alu_16
  import alu16_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  alu_op_t          ctl;
  logic [WIDTH-1:0] x_zero;
  logic [WIDTH-1:0] x_neg;
  logic [WIDTH-1:0] y_zero;
  logic [WIDTH-1:0] y_neg;
  logic [WIDTH-1:0] core;

  assign ctl = alu_op_t'(op);

  // Operand conditioning, function select and output negate
  always_comb begin
    x_zero = ctl.zx ? '0 : x;
    x_neg  = ctl.nx ? ~x_zero : x_zero;
    y_zero = ctl.zy ? '0 : y;
    y_neg  = ctl.ny ? ~y_zero : y_zero;
    core   = ctl.f ? (x_neg + y_neg) : (x_neg & y_neg);
    out    = ctl.no ? ~core : core;
  end

  assign zr = (out == '0);
  assign ng = out[WIDTH-1];

endmodule

// File: rtl/alu16_arbiter.sv
// Round-robin arbiter sharing one Hack ALU between requesters A and B.
// Grant in IDLE latches the winner's operands, EXEC registers the result,
// DONE pulses the winner's done for one cycle.
module alu16_arbiter
  import alu16_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] y_a,
  input  logic [5:0]       op_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] x_b,
  input  logic [WIDTH-1:0] y_b,
  input  logic [5:0]       op_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  grant_t           grant;
  grant_t           winner;
  logic             take;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  alu_16 #(.WIDTH(WIDTH)) u_alu (
    .x   (x_q),
    .y   (y_q),
    .op  (op_q),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // Next-state and grant decision
  always_comb begin
    state_next = state;
    take       = 1'b0;
    winner     = pick_winner(req_a, req_b, grant);
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          take       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant and operand capture; the grant register doubles as last_grant since
  // both always hold the most recent winner. Reset to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= GRANT_B;
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
    end else if (take) begin
      grant <= winner;
      x_q   <= (winner == GRANT_B) ? x_b  : x_a;
      y_q   <= (winner == GRANT_B) ? y_b  : y_a;
      op_q  <= (winner == GRANT_B) ? op_b : op_a;
    end
  end

  // Result and flags registered at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      zr  <= 1'b0;
      ng  <= 1'b0;
    end else if (state == EXEC) begin
      out <= alu_out;
      zr  <= alu_zr;
      ng  <= alu_ng;
    end
  end

  // Done pulses are registered decodes of the DONE state per grant
  always_ff @(posedge clk) begin
    if (reset) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      done_a <= (state == EXEC) && (grant == GRANT_A);
      done_b <= (state == EXEC) && (grant == GRANT_B);
    end
  end

  assign busy = (state == EXEC) || (state == DONE);

endmodule
